// File: rtl/alu_uart_interface.sv
// alu_uart_interface: collects A, B and opcode bytes from a UART receiver, latches the ALU result and hands it to the UART transmitter
module alu_uart_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
);
    typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX} state_t;
    state_t state_q, state_d;
    logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, tx_q, tx_d;
    logic [NB_OP-1:0] op_q, op_d;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            tx_q    <= tx_d;
        end
    end
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        tx_d    = tx_q;
        case (state_q)
            WAIT_A: begin
                a_d     = i_rx_done ? i_rx_data : a_q;
                state_d = i_rx_done ? WAIT_B : WAIT_A;
            end
            WAIT_B: begin
                b_d     = i_rx_done ? i_rx_data : b_q;
                state_d = i_rx_done ? WAIT_OP : WAIT_B;
            end
            WAIT_OP: begin
                op_d    = i_rx_done ? i_rx_data[NB_OP-1:0] : op_q;
                state_d = i_rx_done ? CALC : WAIT_OP;
            end
            CALC: begin
                tx_d    = i_alu_result;
                state_d = SEND;
            end
            SEND:    state_d = WAIT_TX;
            WAIT_TX: state_d = i_tx_done ? WAIT_A : WAIT_TX;
            default: state_d = WAIT_A;
        endcase
    end
    assign o_alu_a    = a_q;
    assign o_alu_b    = b_q;
    assign o_alu_op   = op_q;
    assign o_tx_data  = tx_q;
    assign o_tx_start = !i_reset && state_q == SEND;
    assign o_busy     = !i_reset && (state_q == CALC || state_q == SEND || state_q == WAIT_TX);
endmodule
